// File: rtl/servile_arbiter.sv
// Two-master (SERV ibus/dbus) to one-slave Wishbone arbiter with ibus priority and a grant lock held until ack.
// Optional ack watchdog enabled by defining SERVILE_ARBITER_TIMEOUT_EN.
module servile_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_cpu_dbus_adr,
  input  logic [31:0] i_wb_cpu_dbus_dat,
  input  logic [3:0]  i_wb_cpu_dbus_sel,
  input  logic        i_wb_cpu_dbus_we,
  input  logic        i_wb_cpu_dbus_stb,
  output logic [31:0] o_wb_cpu_dbus_rdt,
  output logic        o_wb_cpu_dbus_ack,
  input  logic [31:0] i_wb_cpu_ibus_adr,
  input  logic        i_wb_cpu_ibus_stb,
  output logic [31:0] o_wb_cpu_ibus_rdt,
  output logic        o_wb_cpu_ibus_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_wb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   sel_i;
  logic   req;
  logic   timeout_hit;

  // While reset is held the routing falls back to the IDLE view even if the
  // registered state still names a master.
  always_comb begin
    sel_i = i_wb_cpu_ibus_stb;
    req   = i_wb_cpu_ibus_stb | i_wb_cpu_dbus_stb;
    if (i_rst_n) begin
      case (state)
        IBUS: begin
          sel_i = 1'b1;
          req   = i_wb_cpu_ibus_stb;
        end
        DBUS: begin
          sel_i = 1'b0;
          req   = i_wb_cpu_dbus_stb;
        end
        default: ;
      endcase
    end
  end

`ifdef SERVILE_ARBITER_TIMEOUT_EN
  logic [15:0] lock_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state == IDLE) lock_cnt <= '0;
    else                           lock_cnt <= lock_cnt + 16'd1;
  end

  // lock_cnt is 0 in the first locked cycle, so the Nth locked cycle sees N-1.
  assign timeout_hit = i_rst_n && (state != IDLE) && req && !i_wb_mem_ack &&
                       (lock_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req && !i_wb_mem_ack) state_nxt = i_wb_cpu_ibus_stb ? IBUS : DBUS;
      IBUS, DBUS: if (i_wb_mem_ack || !req || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  assign o_wb_mem_adr = sel_i ? i_wb_cpu_ibus_adr : i_wb_cpu_dbus_adr;
  assign o_wb_mem_dat = i_wb_cpu_dbus_dat;
  assign o_wb_mem_sel = i_wb_cpu_dbus_sel;
  assign o_wb_mem_we  = i_wb_cpu_dbus_we & ~sel_i;
  assign o_wb_mem_stb = i_rst_n & req & ~timeout_hit;

  assign o_wb_cpu_ibus_ack = i_rst_n & ((i_wb_mem_ack & sel_i & req) | (timeout_hit & sel_i));
  assign o_wb_cpu_dbus_ack = i_rst_n & ((i_wb_mem_ack & ~sel_i & req) | (timeout_hit & ~sel_i));
  assign o_wb_cpu_ibus_rdt = (timeout_hit & sel_i) ? '0 : i_wb_mem_rdt;
  assign o_wb_cpu_dbus_rdt = (timeout_hit & ~sel_i) ? '0 : i_wb_mem_rdt;
  assign o_wb_timeout      = timeout_hit;

endmodule

// File: tb/tb_servile_arbiter.sv
// Bench for servile_arbiter: directed scenarios plus random traffic against an owner/lock-count model.
// Builds with or without SERVILE_ARBITER_TIMEOUT_EN; the watchdog limit is 4.
module tb_servile_arbiter;

  localparam int unsigned TO = 4;
`ifdef SERVILE_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dadr, ddat, iadr, mrdt;
  logic [3:0]  dsel;
  logic        dwe, dstb, istb, mack;
  logic [31:0] drdt, irdt, madr, mdat;
  logic [3:0]  msel;
  logic        dack, iack, mwe, mstb, tmo;

  int checks = 0;
  int failures = 0;
  // Model: owner 0 = nobody, 1 = ibus, 2 = dbus; lockcnt = locked cycles completed.
  int owner = 0;
  int lockcnt = 0;
  logic e_sel, e_req, e_to;

  always #5 clk = ~clk;

  servile_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cpu_dbus_adr(dadr), .i_wb_cpu_dbus_dat(ddat), .i_wb_cpu_dbus_sel(dsel),
    .i_wb_cpu_dbus_we(dwe), .i_wb_cpu_dbus_stb(dstb),
    .o_wb_cpu_dbus_rdt(drdt), .o_wb_cpu_dbus_ack(dack),
    .i_wb_cpu_ibus_adr(iadr), .i_wb_cpu_ibus_stb(istb),
    .o_wb_cpu_ibus_rdt(irdt), .o_wb_cpu_ibus_ack(iack),
    .o_wb_mem_adr(madr), .o_wb_mem_dat(mdat), .o_wb_mem_sel(msel),
    .o_wb_mem_we(mwe), .o_wb_mem_stb(mstb),
    .i_wb_mem_rdt(mrdt), .i_wb_mem_ack(mack),
    .o_wb_timeout(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void calc();
    if (!rst_n || owner == 0) begin
      e_sel = istb;
      e_req = istb | dstb;
    end else begin
      e_sel = (owner == 1);
      e_req = (owner == 1) ? istb : dstb;
    end
    e_to = TO_EN && rst_n && owner != 0 && e_req && !mack && (lockcnt + 1 == int'(TO));
  endfunction

  task automatic check_all();
    calc();
    chk("mem_adr", madr, e_sel ? iadr : dadr);
    chk("mem_dat", mdat, ddat);
    chk("mem_sel", 32'(msel), 32'(dsel));
    chk("mem_we", 32'(mwe), 32'(dwe & !e_sel));
    chk("mem_stb", 32'(mstb), 32'(rst_n & e_req & !e_to));
    chk("ibus_ack", 32'(iack), 32'(rst_n & ((mack & e_sel & e_req) | (e_to & e_sel))));
    chk("dbus_ack", 32'(dack), 32'(rst_n & ((mack & !e_sel & e_req) | (e_to & !e_sel))));
    chk("ibus_rdt", irdt, (e_to && e_sel) ? 32'h0 : mrdt);
    chk("dbus_rdt", drdt, (e_to && !e_sel) ? 32'h0 : mrdt);
    chk("timeout", 32'(tmo), 32'(e_to));
  endtask

  task automatic step();
    int nxt;
    #2;
    check_all();
    @(posedge clk);
    nxt = owner;
    if (!rst_n) nxt = 0;
    else if (owner == 0) begin
      if (e_req && !mack) nxt = istb ? 1 : 2;
    end else if (mack || !e_req || e_to) nxt = 0;
    lockcnt = (nxt != 0 && owner != 0) ? lockcnt + 1 : 0;
    owner = nxt;
    #1;
  endtask

  task automatic clear();
    dadr = '0; ddat = '0; dsel = 4'hF; dwe = 1'b0; dstb = 1'b0;
    iadr = '0; istb = 1'b0; mrdt = 32'hAABBCCDD; mack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear();
    @(posedge clk); #1;
    // Reset: strobe and acks held low even with requests pending
    istb = 1'b1; dstb = 1'b1; mack = 1'b1;
    #2; chk("rst_stb", 32'(mstb), 32'h0); chk("rst_iack", 32'(iack), 32'h0);
    step(); step();
    clear(); rst_n = 1'b1;

    // Instruction fetch
    iadr = 32'h1000; istb = 1'b1;
    #2; chk("fetch_adr", madr, 32'h1000); chk("fetch_stb", 32'(mstb), 32'h1);
    step();
    mack = 1'b1;
    #2; chk("fetch_iack", 32'(iack), 32'h1); chk("fetch_rdt", irdt, 32'hAABBCCDD);
    chk("fetch_dack", 32'(dack), 32'h0);
    step(); clear(); step();

    // Data write
    dadr = 32'h2000; ddat = 32'h11223344; dwe = 1'b1; dstb = 1'b1;
    step();
    mack = 1'b1;
    #2; chk("wr_adr", madr, 32'h2000); chk("wr_we", 32'(mwe), 32'h1); chk("wr_dack", 32'(dack), 32'h1);
    chk("wr_iack", 32'(iack), 32'h0);
    step(); clear(); step();

    // Simultaneous requests: ibus first, then the waiting dbus write
    dadr = 32'h3000; dwe = 1'b1; dstb = 1'b1; iadr = 32'h4000; istb = 1'b1;
    #2; chk("both_adr", madr, 32'h4000); chk("both_we", 32'(mwe), 32'h0);
    step();
    mack = 1'b1; step();
    istb = 1'b0; mack = 1'b0;
    #2; chk("both_dadr", madr, 32'h3000); chk("both_dwe", 32'(mwe), 32'h1);
    step();
    mack = 1'b1; step(); clear(); step();

    // Lock: ibus arriving during a locked dbus transfer waits for the ack
    dadr = 32'h2000; dstb = 1'b1; step();
    iadr = 32'h5000; istb = 1'b1;
    #2; chk("lock_adr", madr, 32'h2000);
    step(); step();
    mack = 1'b1;
    #2; chk("lock_dack", 32'(dack), 32'h1);
    step();
    mack = 1'b0; dstb = 1'b0;
    #2; chk("lock_after", madr, 32'h5000);
    step(); clear(); step();

    // Reset mid-transfer, then a dbus request routed straight from IDLE
    istb = 1'b1; iadr = 32'h7000; step(); step();
    rst_n = 1'b0; mack = 1'b1;
    #2; chk("rmid_stb", 32'(mstb), 32'h0); chk("rmid_iack", 32'(iack), 32'h0);
    step();
    rst_n = 1'b1; mack = 1'b0; istb = 1'b0; dstb = 1'b1; dadr = 32'h6000;
    #2; chk("rmid_adr", madr, 32'h6000); chk("rmid_dstb", 32'(mstb), 32'h1);
    step(); clear(); step();

    // Held ibus with no ack: watchdog fires on the 4th locked cycle, else the lock persists
    istb = 1'b1; iadr = 32'h8000; mrdt = 32'h12345678;
    step();
    for (int i = 1; i <= 12; i++) begin
      if (i == 4 && TO_EN) begin
        #2; chk("to_pulse", 32'(tmo), 32'h1); chk("to_rdt", irdt, 32'h0);
      end
      step();
    end
    clear(); step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      istb  = ($urandom_range(0, 1) != 0);
      dstb  = ($urandom_range(0, 1) != 0);
      mack  = ($urandom_range(0, 3) == 0);
      dwe   = $urandom_range(0, 1) != 0;
      dsel  = 4'($urandom);
      dadr  = $urandom; ddat = $urandom; iadr = $urandom; mrdt = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
